// File: rtl/sint_compare_stream_if.sv
// Valid/ready stream bundle for the compare pipeline: operand/op input side and 1-bit result side.
interface sint_compare_stream_if #(
    parameter int unsigned WIDTH = 8
);
    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic [2:0]       op;
    logic             signed_mode;
    logic             O_valid;
    logic             O_ready;
    logic             O;

    modport master (
        output I_valid, I0, I1, op, signed_mode, O_ready,
        input  I_ready, O_valid, O
    );

    modport slave (
        input  I_valid, I0, I1, op, signed_mode, O_ready,
        output I_ready, O_valid, O
    );
endinterface

// File: rtl/sint_compare_stream.sv
// Pipelined signed/unsigned relational compare with valid/ready flow control and a saturating
// count of true results leaving the pipeline.
module sint_compare_stream #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    sint_compare_stream_if.slave    bus,
    input  logic                    count_clear,
    output logic [COUNT_WIDTH-1:0]  hit_count
);
    typedef enum logic [2:0] {
        OpLt = 3'd0,
        OpLe = 3'd1,
        OpGt = 3'd2,
        OpGe = 3'd3,
        OpEq = 3'd4,
        OpNe = 3'd5
    } op_e;

    logic lt, eq, res;

    always_comb begin
        eq = (bus.I0 == bus.I1);
        if (bus.signed_mode) begin
            lt = ($signed(bus.I0) < $signed(bus.I1));
        end else begin
            lt = (bus.I0 < bus.I1);
        end
        case (bus.op)
            OpLt:    res = lt;
            OpLe:    res = lt | eq;
            OpGt:    res = ~(lt | eq);
            OpGe:    res = ~lt;
            OpEq:    res = eq;
            OpNe:    res = ~eq;
            default: res = 1'b0;
        endcase
    end

    logic [LATENCY-1:0] v_q, v_d, r_q, r_d, adv;
    logic               adv_chain;

    // Advance propagates back from the output; result bits are kept zero in empty stages.
    always_comb begin
        adv_chain = ~v_q[LATENCY-1] | bus.O_ready;
        adv       = '0;
        adv[LATENCY-1] = adv_chain;
        for (int k = int'(LATENCY) - 2; k >= 0; k--) begin
            adv_chain = ~v_q[k] | adv_chain;
            adv[k]    = adv_chain;
        end

        v_d = v_q;
        r_d = r_q;
        if (adv[0]) begin
            v_d[0] = bus.I_valid;
            r_d[0] = bus.I_valid & res;
        end
        for (int k = 1; k < int'(LATENCY); k++) begin
            if (adv[k]) begin
                v_d[k] = v_q[k-1];
                r_d[k] = r_q[k-1];
            end
        end
    end

    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   inc;

    assign inc = bus.O_valid & bus.O_ready & bus.O;

    always_comb begin
        cnt_d = cnt_q;
        if (count_clear) begin
            cnt_d    = '0;
            cnt_d[0] = inc;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            v_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            r_q   <= r_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.I_ready = adv[0];
    assign bus.O_valid = v_q[LATENCY-1];
    assign bus.O       = r_q[LATENCY-1];
    assign hit_count   = cnt_q;
endmodule

// File: tb/tb_sint_compare_stream.sv
// Directed bench for sint_compare_stream: queue-based reference model checked every cycle, plus
// literal expectations for latency, op sweep, stall, saturation and reset flush.
module tb_sint_compare_stream;
    localparam int unsigned W   = 3;
    localparam int unsigned LAT = 2;
    localparam int unsigned CW  = 2;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          count_clear;
    logic [CW-1:0] hit_count;

    sint_compare_stream_if #(.WIDTH(W)) bus ();

    sint_compare_stream #(
        .WIDTH       (W),
        .LATENCY     (LAT),
        .COUNT_WIDTH (CW)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .bus         (bus),
        .count_clear (count_clear),
        .hit_count   (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int out_xfers = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: relation evaluated on plain integers.
    function automatic bit model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input logic sm);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (sm && a[W-1]) sa = sa - (1 << W);
        if (sm && b[W-1]) sb = sb - (1 << W);
        case (op)
            3'd0:    return sa < sb;
            3'd1:    return sa <= sb;
            3'd2:    return sa > sb;
            3'd3:    return sa >= sb;
            3'd4:    return sa == sb;
            3'd5:    return sa != sb;
            default: return 1'b0;
        endcase
    endfunction

    bit exp_q[$];
    int mcnt = 0;
    bit prev_stall = 0;
    bit prev_o = 0;

    always @(negedge clk) begin
        bit inc_m;
        if (rst) begin
            exp_q.delete();
            mcnt       = 0;
            prev_stall = 0;
        end else begin
            check("hit_count_model", int'(hit_count), mcnt);
            if (prev_stall) begin
                check("hold_valid", int'(bus.O_valid), 1);
                check("hold_o", int'(bus.O), int'(prev_o));
            end
            if (bus.O_valid) begin
                check("result_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("result_order", int'(bus.O), int'(exp_q[0]));
            end
            inc_m = 1'b0;
            if (bus.O_valid && bus.O_ready) begin
                out_xfers++;
                if (exp_q.size() > 0) inc_m = exp_q.pop_front();
            end
            if (count_clear) mcnt = int'(inc_m);
            else if (inc_m && mcnt < CNT_MAX) mcnt++;
            if (bus.I_valid && bus.I_ready)
                exp_q.push_back(model(bus.I0, bus.I1, bus.op, bus.signed_mode));
            prev_stall = bus.O_valid && !bus.O_ready;
            prev_o     = bus.O;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic sm, output int tries);
        bit acc;
        bus.I_valid     = 1'b1;
        bus.I0          = a;
        bus.I1          = b;
        bus.op          = op;
        bus.signed_mode = sm;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 100) begin
            @(negedge clk);
            acc = bus.I_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!acc) check("send_accept_timeout", 0, 1);
        bus.I_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        step();
        check(name, exp_q.size(), 0);
    endtask

    bit exp_s[6] = '{1, 1, 0, 0, 0, 1};
    bit exp_u[6] = '{0, 0, 1, 1, 0, 1};
    int tr;
    int x0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        count_clear     = 1'b0;
        bus.I_valid     = 1'b0;
        bus.I0          = '0;
        bus.I1          = '0;
        bus.op          = '0;
        bus.signed_mode = 1'b0;
        bus.O_ready     = 1'b1;

        // Pin the reference model against hand values.
        check("model_s_lt", int'(model(3'b111, 3'b001, 3'd0, 1'b1)), 1);
        check("model_u_lt", int'(model(3'b111, 3'b001, 3'd0, 1'b0)), 0);
        check("model_s_gt", int'(model(3'b100, 3'b011, 3'd2, 1'b1)), 0);
        check("model_rsv",  int'(model(3'b000, 3'b000, 3'd7, 1'b0)), 0);

        repeat (3) step();
        rst = 1'b0;
        check("rst_ovalid", int'(bus.O_valid), 0);
        check("rst_o", int'(bus.O), 0);
        check("rst_count", int'(hit_count), 0);
        check("rst_iready", int'(bus.I_ready), 1);

        // Latency and signedness.
        send(3'b111, 3'b001, 3'd0, 1'b1, tr);
        check("lat_early_valid", int'(bus.O_valid), 0);
        step();
        check("lat_valid", int'(bus.O_valid), 1);
        check("lat_s_lt", int'(bus.O), 1);
        step();
        send(3'b111, 3'b001, 3'd0, 1'b0, tr);
        step();
        check("lat_u_valid", int'(bus.O_valid), 1);
        check("lat_u_lt", int'(bus.O), 0);
        step();

        // Op sweep on -4 vs +3.
        for (int s = 0; s < 2; s++) begin
            for (int op = 0; op < 7; op++) begin
                send(3'b100, 3'b011, 3'(op), 1'(1 - s), tr);
                step();
                check("sweep_valid", int'(bus.O_valid), 1);
                if (op == 6) check("sweep_rsv", int'(bus.O), 0);
                else if (s == 0) check("sweep_signed", int'(bus.O), int'(exp_s[op]));
                else check("sweep_unsigned", int'(bus.O), int'(exp_u[op]));
                step();
            end
        end
        drain("drain_sweep");

        // Back-to-back stream, full throughput.
        x0 = out_xfers;
        for (int i = 0; i < 10; i++) begin
            send(3'(i), 3'(7 - i), 3'(i % 6), 1'(i % 2), tr);
            check("stream_iready", tr, 1);
        end
        step();
        step();
        check("stream_consecutive", out_xfers - x0, 10);
        drain("drain_stream");

        // Stall with pipeline full.
        bus.O_ready = 1'b0;
        send(3'b001, 3'b010, 3'd0, 1'b0, tr);
        send(3'b110, 3'b010, 3'd2, 1'b1, tr);
        bus.I_valid = 1'b1;
        bus.I0 = 3'b011;
        bus.I1 = 3'b011;
        bus.op = 3'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_iready", int'(bus.I_ready), 0);
            check("stall_ovalid", int'(bus.O_valid), 1);
            @(posedge clk);
            #1;
        end
        bus.O_ready = 1'b1;
        send(3'b011, 3'b011, 3'd4, 1'b0, tr);
        check("stall_release_accept", tr, 1);
        drain("drain_stall");

        // Saturating counter with COUNT_WIDTH=2.
        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        check("cnt_cleared", int'(hit_count), 0);
        for (int i = 0; i < 5; i++) begin
            send(3'b101, 3'b101, 3'd4, 1'b0, tr);
            step();
            step();
            check("cnt_sat", int'(hit_count), (i < 3) ? i + 1 : 3);
        end
        send(3'b101, 3'b101, 3'd4, 1'b0, tr);
        step();
        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        check("cnt_clear_inc", int'(hit_count), 1);
        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        check("cnt_clear_alone", int'(hit_count), 0);

        // Reset with results in flight.
        send(3'b010, 3'b010, 3'd4, 1'b0, tr);
        step();
        step();
        check("pre_rst_count", int'(hit_count), 1);
        bus.O_ready = 1'b0;
        send(3'b000, 3'b001, 3'd0, 1'b0, tr);
        send(3'b001, 3'b001, 3'd4, 1'b0, tr);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_ovalid", int'(bus.O_valid), 0);
        check("midrst_count", int'(hit_count), 0);
        bus.O_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale", int'(bus.O_valid), 0);
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
